// File: rtl/instr_seq.sv
// instr_seq: single-issue instruction sequencer. It fetches words from imem
// starting at RESET_PC, presents each one to the core for exactly one cycle,
// and halts on ECALL/EBREAK or when a fetch goes unanswered too long.
// Optional feature macro: INSTR_SEQ_STEP_EN adds step_mode/step inputs and a
// PAUSE state used for single-stepping.
module instr_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
`ifdef INSTR_SEQ_STEP_EN
    input  logic        step_mode,
    input  logic        step,
`endif
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] core_instr,
    output logic        core_issue,
    output logic [31:0] pc,
    output logic [31:0] retired_cnt,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
`ifdef INSTR_SEQ_STEP_EN
        , PAUSE
`endif
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] instr_q;
    logic [7:0]  tmo_cnt;
    logic        do_start;
    logic        do_latch;
    logic        do_retire;
    logic        do_tmo;

    function automatic logic is_halt(input logic [31:0] w);
        return (w == ECALL) || (w == EBREAK);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state decode; abort outranks every other exit condition
    always_comb begin
        state_d   = state;
        do_start  = 1'b0;
        do_latch  = 1'b0;
        do_retire = 1'b0;
        do_tmo    = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start && !abort) begin
                    state_d  = FETCH;
                    do_start = 1'b1;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (imem_valid) begin
                    do_latch = 1'b1;
                    state_d  = is_halt(imem_rdata) ? HALTED : ISSUE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = HALTED;
                    do_tmo  = 1'b1;
                end
            end
            ISSUE: begin
                // the instruction on the bus this cycle retires even if aborted
                do_retire = 1'b1;
                if (abort) state_d = IDLE;
`ifdef INSTR_SEQ_STEP_EN
                else if (step_mode) state_d = PAUSE;
`endif
                else state_d = FETCH;
            end
`ifdef INSTR_SEQ_STEP_EN
            PAUSE: begin
                if (abort)     state_d = IDLE;
                else if (step) state_d = FETCH;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: pc, retirement count, error flag, timeout, instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            retired_cnt <= '0;
            err         <= 1'b0;
            tmo_cnt     <= '0;
            instr_q     <= NOP;
        end else begin
            if (do_start) begin
                pc          <= RESET_PC;
                retired_cnt <= '0;
                err         <= 1'b0;
            end
            if (do_latch) instr_q <= imem_rdata;
            if (do_retire) begin
                pc <= pc + 32'd4;
                if (retired_cnt != '1) retired_cnt <= retired_cnt + 32'd1;
            end
            if (do_tmo) err <= 1'b1;
            if (state == FETCH && !imem_valid) tmo_cnt <= tmo_cnt + 8'd1;
            else                               tmo_cnt <= '0;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        imem_req   = (state == FETCH);
        imem_addr  = pc;
        core_issue = (state == ISSUE);
        core_instr = (state == ISSUE) ? instr_q : NOP;
        halted     = (state == HALTED);
`ifdef INSTR_SEQ_STEP_EN
        busy       = (state == FETCH) || (state == ISSUE) || (state == PAUSE);
`else
        busy       = (state == FETCH) || (state == ISSUE);
`endif
    end

endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: randomized scoreboard bench for instr_seq. Stimulus pushes the
// expected {pc, instruction} of every word that should issue; a monitor pops
// and compares on each core_issue pulse.
module tb_instr_seq;

    localparam logic [31:0] RPC    = 32'hFFFF_FFFC;
    localparam int          TMO    = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] core_instr;
    logic        core_issue;
    logic [31:0] pc;
    logic [31:0] retired_cnt;
    logic        busy;
    logic        halted;
    logic        err;
`ifdef INSTR_SEQ_STEP_EN
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
`endif

    instr_seq #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef INSTR_SEQ_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .core_instr(core_instr), .core_issue(core_issue),
        .pc(pc), .retired_cnt(retired_cnt),
        .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    int unsigned issue_cyc[$];
    logic [31:0] prog[16];
    logic [63:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every issue must match the oldest expected word; otherwise NOP
    always @(negedge clk) begin
        if (core_issue) begin
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_issue: got instr %h at pc %h, required no issue", core_instr, pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_instr", core_instr, mon_e[31:0]);
                chk("issue_pc", pc, mon_e[63:32]);
            end
        end else begin
            chk("idle_nop", core_instr, NOP);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == ECALL || w == EBREAK) w = w ^ 32'h100;
        return w;
    endfunction

    // Reference: a run issues every word before the first halt word, in order
    task automatic expect_prog(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({RPC + 32'(4 * i), prog[i]});
    endtask

    // Memory responder: random stalls of at most max_gap cycles, noise outside FETCH
    task automatic drive_mem(input int max_gap, inout int gap);
        if (imem_req) begin
            if (gap < max_gap && $urandom_range(0, 2) == 0) begin
                imem_valid = 1'b0;
                imem_rdata = $urandom;
                gap++;
            end else begin
                imem_valid = 1'b1;
                imem_rdata = prog[4'((imem_addr - RPC) >> 2)];
                gap = 0;
            end
        end else begin
            imem_valid = 1'($urandom);
            imem_rdata = $urandom;
            gap = 0;
        end
    endtask

    task automatic wait_halt(input int max_gap, input string tag);
        int gap;
        bit done;
        gap = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (halted) done = 1'b1;
            else begin
                drive_mem(max_gap, gap);
                tick();
            end
        end
        if (halted) done = 1'b1;
        imem_valid = 1'b0;
        chk({tag, "_halt_reached"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;
        int unsigned t0;
        int          n;

        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_issue", 32'(core_issue), 32'd0);
        chk("rst_instr", core_instr, NOP);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc", pc, RPC);
        chk("rst_retired", retired_cnt, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Two words then ECALL at full rate, crossing the address wrap
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = ECALL;
        expect_prog(2);
        issue_cyc.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halt(0, "basic");
        chk("basic_issues", 32'(issue_cyc.size()), 32'd2);
        if (issue_cyc.size() == 2) chk("basic_spacing", issue_cyc[1] - issue_cyc[0], 32'd2);
        chk("basic_retired", retired_cnt, 32'd2);
        chk("basic_pc", pc, RPC + 32'd8);
        chk("basic_err", 32'(err), 32'd0);
        chk("basic_pending", 32'(exp_q.size()), 32'd0);

        // Fetch timeout with no response at all
        exp_q.delete();
        issue_cyc.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
        chk("tmo_req", 32'(imem_req), 32'd1);
        for (int c = 0; c < 20 && !halted; c++) begin
            imem_valid = 1'b0;
            tick();
        end
        chk("tmo_latency", cyc - t0, 32'(TMO));
        chk("tmo_halted", 32'(halted), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_retired", retired_cnt, 32'd0);
        chk("tmo_issues", 32'(issue_cyc.size()), 32'd0);

        // Longest legal stall: response arrives in the last allowed cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("gap_err_cleared", 32'(err), 32'd0);
        for (int c = 0; c < TMO - 1; c++) begin
            imem_valid = 1'b0;
            tick();
        end
        chk("gap_still_fetch", 32'(imem_req), 32'd1);
        imem_valid = 1'b1;
        imem_rdata = EBREAK;
        tick();
        imem_valid = 1'b0;
        chk("gap_halted", 32'(halted), 32'd1);
        chk("gap_err", 32'(err), 32'd0);

        // Random programs with random stalls, each restarted from HALTED
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 6);
            for (int i = 0; i < 16; i++) prog[i] = rand_word();
            prog[n] = ($urandom_range(0, 1) == 1) ? EBREAK : ECALL;
            exp_q.delete();
            expect_prog(n);
            start = 1'b1;
            tick();
            start = 1'b0;
            wait_halt(TMO - 1, "rand");
            chk("rand_retired", retired_cnt, 32'(n));
            chk("rand_pc", pc, RPC + 32'(4 * n));
            chk("rand_err", 32'(err), 32'd0);
            chk("rand_pending", 32'(exp_q.size()), 32'd0);
        end

        // Abort during ISSUE: the word still issues and counts
        w0 = rand_word();
        exp_q.delete();
        exp_q.push_back({RPC, w0});
        issue_cyc.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = w0;
        tick();
        chk("abi_issue", 32'(core_issue), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abi_busy", 32'(busy), 32'd0);
        chk("abi_halted", 32'(halted), 32'd0);
        chk("abi_retired", retired_cnt, 32'd1);
        for (int c = 0; c < 3; c++) begin
            imem_valid = 1'b1;
            imem_rdata = rand_word();
            tick();
        end
        imem_valid = 1'b0;
        chk("abi_idle_busy", 32'(busy), 32'd0);
        chk("abi_idle_retired", retired_cnt, 32'd1);
        chk("abi_issues", 32'(issue_cyc.size()), 32'd1);
        chk("abi_pending", 32'(exp_q.size()), 32'd0);

        // Abort during the second FETCH beats a valid response; pc holds
        w0 = rand_word();
        w1 = rand_word();
        exp_q.push_back({RPC, w0});
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = w0;
        tick();
        imem_valid = 1'b0;
        tick();
        chk("abf_req", 32'(imem_req), 32'd1);
        chk("abf_addr", imem_addr, RPC + 32'd4);
        abort = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = w1;
        tick();
        abort = 1'b0;
        imem_valid = 1'b0;
        chk("abf_busy", 32'(busy), 32'd0);
        chk("abf_pc", pc, RPC + 32'd4);
        chk("abf_retired", retired_cnt, 32'd1);
        chk("abf_pending", 32'(exp_q.size()), 32'd0);

        // start together with abort: abort wins in IDLE and in HALTED
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_idle_busy", 32'(busy), 32'd0);
        chk("sa_idle_halted", 32'(halted), 32'd0);
        prog[0] = ECALL;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_halt(0, "sa");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_halted", 32'(halted), 32'd1);
        chk("sa_halted_busy", 32'(busy), 32'd0);

        // Reset in the middle of FETCH
        w0 = rand_word();
        exp_q.push_back({RPC, w0});
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = w0;
        tick();
        imem_valid = 1'b0;
        tick();
        chk("rmid_pre_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = rand_word();
        #1;
        chk("rmid_req", 32'(imem_req), 32'd0);
        chk("rmid_pc", pc, RPC);
        chk("rmid_busy", 32'(busy), 32'd0);
        chk("rmid_retired", retired_cnt, 32'd0);
        chk("rmid_issue", 32'(core_issue), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        imem_valid = 1'b0;
        chk("rmid_after_busy", 32'(busy), 32'd0);
        chk("rmid_after_halted", 32'(halted), 32'd0);
        chk("rmid_after_retired", retired_cnt, 32'd0);
        chk("rmid_pending", 32'(exp_q.size()), 32'd0);

`ifdef INSTR_SEQ_STEP_EN
        // Single-step: each issue parks in PAUSE until a step pulse
        issue_cyc.delete();
        for (int i = 0; i < 3; i++) prog[i] = rand_word();
        prog[3] = ECALL;
        expect_prog(3);
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int g;
            g = 0;
            for (int c = 0; c < 20 && !core_issue; c++) begin
                drive_mem(0, g);
                tick();
            end
            chk("step_issue", 32'(core_issue), 32'd1);
            imem_valid = 1'b0;
            tick();
            for (int p = 0; p < 3; p++) begin
                chk("step_pause_busy", 32'(busy), 32'd1);
                chk("step_pause_req", 32'(imem_req), 32'd0);
                imem_valid = 1'b1;
                imem_rdata = rand_word();
                tick();
            end
            chk("step_retired", retired_cnt, 32'(k + 1));
            imem_valid = 1'b0;
            step = 1'b1;
            tick();
            step = 1'b0;
        end
        wait_halt(0, "step");
        chk("step_issues", 32'(issue_cyc.size()), 32'd3);
        chk("step_pending", 32'(exp_q.size()), 32'd0);
        step_mode = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 Param RESET_PC, default 32'h0000_0000: byte address of the first fetch after start.
REQ-002 Param TIMEOUT, default 16, legal range 2..255: maximum FETCH cycles without imem_valid before an error halt.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a run; honoured only in IDLE or HALTED.
REQ-006 abort  input  1  synchronous abort to IDLE.
REQ-007 imem_req  output  1  fetch request, held high for the whole FETCH state.
REQ-008 imem_addr  output  32  fetch address; equals pc.
REQ-009 imem_valid  input  1  fetch response valid; sampled only in FETCH.
REQ-010 imem_rdata  input  32  fetched instruction; sampled when imem_valid=1 in FETCH.
REQ-011 core_instr  output  32  instruction presented to the core datapath.
REQ-012 core_issue  output  1  high for exactly the cycle core_instr carries a real instruction.
REQ-013 pc  output  32  current program counter.
REQ-014 retired_cnt  output  32  count of issued instructions in the current run.
REQ-015 busy  output  1  high in FETCH, ISSUE and PAUSE.
REQ-016 halted  output  1  high in HALTED.
REQ-017 err  output  1  fetch-timeout flag; valid in HALTED.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, ISSUE, HALTED, plus PAUSE when INSTR_SEQ_STEP_EN is defined.
REQ-019 In IDLE or HALTED with start=1: next state FETCH, pc<=RESET_PC, retired_cnt<=0, err<=0, timeout counter<=0.
REQ-020 start SHALL be ignored in FETCH, ISSUE and PAUSE.
REQ-021 In FETCH, imem_req=1 and imem_addr=pc; the timeout counter resets to 0 on every entry.
REQ-022 In FETCH with imem_valid=1, the block SHALL latch imem_rdata into an instruction register.
REQ-023 Halt decode: if the latched word is ECALL 32'h0000_0073 or EBREAK 32'h0010_0073, next state is HALTED with err=0; the word is not issued.
REQ-024 Otherwise, with imem_valid=1, next state is ISSUE.
REQ-025 In FETCH with imem_valid=0, the timeout counter increments; when it equals TIMEOUT-1, next state is HALTED with err<=1.
REQ-026 In ISSUE (exactly 1 cycle): core_issue=1 and core_instr equals the latched word.
REQ-027 On leaving ISSUE: pc<=pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-028 On leaving ISSUE: retired_cnt increments, saturating at 32'hFFFF_FFFF.
REQ-029 On leaving ISSUE: next state is FETCH, or PAUSE when INSTR_SEQ_STEP_EN is defined and step mode is active.
REQ-030 In all states except ISSUE: core_issue=0 and core_instr=32'h0000_0013 (addi x0,x0,0), so the core performs no architectural write.
REQ-031 Minimum sustained rate: 1 instruction per 2 cycles (zero-latency imem_valid).
REQ-032 abort=1 in FETCH, ISSUE or PAUSE: next state IDLE; pc, retired_cnt and err hold.
REQ-033 abort SHALL NOT alter current-cycle outputs; an instruction in ISSUE is still issued and counted.
REQ-034 abort has priority over imem_valid, timeout and step.
REQ-035 abort in IDLE or HALTED has no effect; start and abort both high in IDLE or HALTED: abort wins (remain put).
REQ-036 Outputs SHALL be driven from registered state only; no combinational path from imem_valid or imem_rdata to core_instr or core_issue.

Reset
REQ-037 On rst=1, asynchronously: state=IDLE, pc=RESET_PC, retired_cnt=0, err=0, timeout counter=0, instruction register=32'h0000_0013.
REQ-038 During and after reset, outputs SHALL be: imem_req=0, core_issue=0, core_instr=32'h0000_0013, busy=0, halted=0.
REQ-039 Reset asserted mid-run SHALL discard any outstanding fetch; a later imem_valid outside FETCH is ignored.

Configuration
REQ-040 Macro INSTR_SEQ_STEP_EN, when defined, SHALL add inputs step_mode (1) and step (1) and state PAUSE.
REQ-041 With the macro: if step_mode=1, ISSUE exits to PAUSE; PAUSE exits to FETCH on step=1; otherwise PAUSE holds.
REQ-042 Without the macro: the ports and PAUSE do not exist, and ISSUE always exits to FETCH.

Verification
REQ-043 rst, start, imem_valid=1 same cycle with words 0x00500093, 0x00A00113, 0x00000073 -> two core_issue pulses 2 cycles apart; then HALTED, retired_cnt=2, pc=8, err=0.
REQ-044 TIMEOUT=4, start, imem_valid held 0 -> HALTED 4 cycles after FETCH entry, err=1, retired_cnt=0, core_issue never high.
REQ-045 RESET_PC=32'hFFFF_FFFC, one non-halt word issued -> next imem_addr=0.
REQ-046 abort in the ISSUE cycle -> that instruction issued, retired_cnt=1, IDLE next cycle; imem_valid=1 in IDLE ignored.
REQ-047 rst pulsed mid-FETCH -> immediate IDLE, pc=RESET_PC, imem_req=0 the same cycle.
REQ-048 INSTR_SEQ_STEP_EN, step_mode=1 -> after each issue remain in PAUSE until a step pulse; 3 step pulses -> 3 issues.
